mult_sequencer: RTL and testbench

//  Control FSM for the shift-and-add multiplier datapath: result register (clear/load),
//  A/B shift registers (load/shift) and adder enable. Synchronises and edge-detects the
//  raw start button, bounds the iteration count, and reports completion via done/ack.

---
 rtl/mult_sequencer.sv | 91 +++++++++
 tb/tb_mult_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: control FSM for a shift-and-add multiplier datapath.
// Synchronises and edge-detects the start button, bounds iterations, and hands off via done/ack.
module mult_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ITER    = 16,
    parameter int CW          = 5
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    input  logic          start_butt,
    input  logic          ack,
    input  logic          a_zero,
    input  logic          b_zero,
    input  logic          b_lsb,
    output logic          clear_rez,
    output logic          load_ab,
    output logic          add_en,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic          limit_hit,
    output logic [CW-1:0] iter_cnt
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, CHECK, ADD, SHIFT, DONE} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sync, fill;
    logic                   edge_q, armed, start_pulse, limit_nx;
    logic [CW-1:0]          iter_nx;

    // armed stays low until the synchronised button has been seen released after reset,
    // so a button already held through reset cannot launch an operation
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sync        <= '0;
            fill        <= '0;
            edge_q      <= 1'b0;
            armed       <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], start_butt};
            fill        <= {fill[SYNC_STAGES-2:0], 1'b1};
            edge_q      <= sync[SYNC_STAGES-1];
            armed       <= armed | (fill[SYNC_STAGES-1] & ~sync[SYNC_STAGES-1]);
            start_pulse <= armed & sync[SYNC_STAGES-1] & ~edge_q;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state     <= IDLE;
            iter_cnt  <= '0;
            limit_hit <= 1'b0;
        end else begin
            state     <= state_nx;
            iter_cnt  <= iter_nx;
            limit_hit <= limit_nx;
        end
    end

    always_comb begin
        state_nx = IDLE;
        iter_nx  = iter_cnt;
        limit_nx = limit_hit;
        case (state)
            IDLE:  state_nx = start_pulse ? CLEAR : IDLE;
            CLEAR: begin
                state_nx = LOAD;
                iter_nx  = '0;
                limit_nx = 1'b0;
            end
            LOAD:  state_nx = CHECK;
            CHECK: state_nx = (a_zero | b_zero) ? DONE : (b_lsb ? ADD : SHIFT);
            ADD:   state_nx = SHIFT;
            SHIFT: begin
                iter_nx  = (iter_cnt >= CW'(MAX_ITER)) ? iter_cnt : iter_cnt + 1'b1;
                state_nx = (iter_cnt >= CW'(MAX_ITER - 1)) ? DONE : CHECK;
                limit_nx = (iter_cnt >= CW'(MAX_ITER - 1)) | limit_hit;
            end
            DONE:  state_nx = ack ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    assign clear_rez = state == CLEAR;
    assign load_ab   = state == LOAD;
    assign add_en    = state == ADD;
    assign shift_en  = state == SHIFT;
    assign done      = state == DONE;
    assign busy      = state inside {CLEAR, LOAD, CHECK, ADD, SHIFT};
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed bench with a shift-and-add datapath model around the sequencer,
// plus a second instance with MAX_ITER=4 and pinned flags for the iteration limit.
module tb_mult_sequencer;
    logic        clk_100MHz = 1'b0, reset = 1'b1, start_butt = 1'b0, ack = 1'b0;
    logic        start4 = 1'b0, ack4 = 1'b0;
    logic [15:0] a_in = 16'd0, a_reg = 16'd0, rez = 16'd0;
    logic [7:0]  b_in = 8'd0, b_reg = 8'd0;
    logic        clear_rez, load_ab, add_en, shift_en, busy, done, limit_hit;
    logic [4:0]  iter_cnt;
    logic        clear4, load4, add4, shift4, busy4, done4, limit4;
    logic [2:0]  iter4;
    int          n_cmp = 0, n_bad = 0;
    int          n_add = 0, n_shift = 0, n_clear = 0, n_add4 = 0, n_shift4 = 0;
    int          b_add, b_shift, b_clear, cyc;

    always #5 clk_100MHz = ~clk_100MHz;

    mult_sequencer dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .start_butt(start_butt), .ack(ack),
        .a_zero(a_reg == 16'd0), .b_zero(b_reg == 8'd0), .b_lsb(b_reg[0]),
        .clear_rez(clear_rez), .load_ab(load_ab), .add_en(add_en), .shift_en(shift_en),
        .busy(busy), .done(done), .limit_hit(limit_hit), .iter_cnt(iter_cnt)
    );

    mult_sequencer #(.SYNC_STAGES(2), .MAX_ITER(4), .CW(3)) dut4 (
        .clk_100MHz(clk_100MHz), .reset(reset), .start_butt(start4), .ack(ack4),
        .a_zero(1'b0), .b_zero(1'b0), .b_lsb(1'b1),
        .clear_rez(clear4), .load_ab(load4), .add_en(add4), .shift_en(shift4),
        .busy(busy4), .done(done4), .limit_hit(limit4), .iter_cnt(iter4)
    );

    always @(posedge clk_100MHz) begin
        if (clear_rez) rez <= 16'd0;
        else if (add_en) rez <= rez + a_reg;
        if (load_ab) begin
            a_reg <= a_in;
            b_reg <= b_in;
        end else if (shift_en) begin
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
        end
        n_add    <= n_add + int'(add_en);
        n_shift  <= n_shift + int'(shift_en);
        n_clear  <= n_clear + int'(clear_rez);
        n_add4   <= n_add4 + int'(add4);
        n_shift4 <= n_shift4 + int'(shift4);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    // sel: 0 clear_rez, 1 done, 2 done4, 3 add_en after the first shift
    task automatic wait_until(input string tag, input int sel, input int lim, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < lim) begin
            @(negedge clk_100MHz);
            n++;
            hit = (sel == 0) ? clear_rez : (sel == 1) ? done : (sel == 2) ? done4
                : (add_en && iter_cnt != 5'd0);
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        tick(3);
        check("rst_outs", 32'({clear_rez, load_ab, add_en, shift_en, busy, done, limit_hit}), 32'd0);
        check("rst_iter", 32'(iter_cnt), 32'd0);
        check("rst_outs4", 32'({clear4, load4, add4, shift4, busy4, done4, limit4, iter4}), 32'd0);
        reset = 1'b0;
        tick(8);

        // 3 x 5 with start latency and CLEAR-to-DONE timing
        a_in = 16'd3; b_in = 8'd5; b_clear = n_clear;
        start_butt = 1'b1;
        tick(3);
        check("lat_early", 32'(clear_rez), 32'd0);
        tick(1);
        check("lat_clear", 32'(clear_rez), 32'd1);
        check("clear_busy", 32'(busy), 32'd1);
        b_add = n_add; b_shift = n_shift;
        wait_until("op1_done", 1, 40, cyc);
        check("op1_cycles", 32'(cyc), 32'd11);
        check("op1_adds", 32'(n_add - b_add), 32'd2);
        check("op1_shifts", 32'(n_shift - b_shift), 32'd3);
        check("op1_iter", 32'(iter_cnt), 32'd3);
        check("op1_limit", 32'(limit_hit), 32'd0);
        check("op1_busy", 32'(busy), 32'd0);
        check("op1_product", 32'(rez), 32'd15);
        tick(20);
        check("done_held", 32'(done), 32'd1);
        start_butt = 1'b0;
        tick(4);
        start_butt = 1'b1;
        tick(6);
        check("start_in_done", 32'(done), 32'd1);
        start_butt = 1'b0;
        ack = 1'b1;
        tick(1);
        check("ack_idle", 32'({busy, done}), 32'd0);
        ack = 1'b0;
        tick(8);
        check("no_queue", 32'(n_clear - b_clear), 32'd1);

        // B = 0: CLEAR, LOAD, CHECK, DONE with no strobes
        a_in = 16'd7; b_in = 8'd0; b_add = n_add; b_shift = n_shift;
        start_butt = 1'b1;
        wait_until("bz_clear", 0, 10, cyc);
        tick(1);
        check("bz_load", 32'(load_ab), 32'd1);
        tick(1);
        check("bz_check", 32'({clear_rez, load_ab, add_en, shift_en, busy, done}), 32'b000010);
        tick(1);
        check("bz_done", 32'(done), 32'd1);
        check("bz_iter", 32'(iter_cnt), 32'd0);
        check("bz_limit", 32'(limit_hit), 32'd0);
        check("bz_strobes", 32'(n_add - b_add + n_shift - b_shift), 32'd0);
        start_butt = 1'b0;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(4);

        // long hold gives one operation
        a_in = 16'd3; b_in = 8'd5; b_clear = n_clear;
        start_butt = 1'b1;
        tick(1000);
        check("hold_ops", 32'(n_clear - b_clear), 32'd1);
        check("hold_done", 32'(done), 32'd1);
        check("hold_product", 32'(rez), 32'd15);
        start_butt = 1'b0;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(4);

        // re-press while busy is ignored
        b_clear = n_clear;
        start_butt = 1'b1;
        wait_until("rp_clear", 0, 10, cyc);
        start_butt = 1'b0;
        tick(1);
        start_butt = 1'b1;
        tick(2);
        start_butt = 1'b0;
        wait_until("rp_done", 1, 40, cyc);
        tick(10);
        check("rp_ops", 32'(n_clear - b_clear), 32'd1);
        check("rp_done_held", 32'(done), 32'd1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(4);

        // reset mid-ADD with the button held through reset
        b_clear = n_clear;
        start_butt = 1'b1;
        wait_until("mid_add", 3, 40, cyc);
        reset = 1'b1;
        tick(1);
        check("rst_mid_outs", 32'({clear_rez, load_ab, add_en, shift_en, busy, done, limit_hit}), 32'd0);
        check("rst_mid_iter", 32'(iter_cnt), 32'd0);
        reset = 1'b0;
        tick(20);
        check("held_reset_ops", 32'(n_clear - b_clear), 32'd1);
        check("held_reset_busy", 32'(busy), 32'd0);
        start_butt = 1'b0;
        tick(5);
        start_butt = 1'b1;
        wait_until("repress_clear", 0, 10, cyc);
        wait_until("repress_done", 1, 40, cyc);
        check("repress_product", 32'(rez), 32'd15);
        check("repress_iter", 32'(iter_cnt), 32'd3);
        start_butt = 1'b0;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;

        // iteration limit on the MAX_ITER=4 instance
        b_add = n_add4; b_shift = n_shift4;
        start4 = 1'b1;
        wait_until("lim_done", 2, 60, cyc);
        check("lim_adds", 32'(n_add4 - b_add), 32'd4);
        check("lim_shifts", 32'(n_shift4 - b_shift), 32'd4);
        check("lim_hit", 32'(limit4), 32'd1);
        check("lim_iter", 32'(iter4), 32'd4);
        start4 = 1'b0;
        ack4 = 1'b1;
        tick(1);
        check("lim_ack", 32'({busy4, done4}), 32'd0);
        ack4 = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
